tlb_op_sequencer: RTL and testbench

- Sequences the four TLB-maintenance instructions (TLBR, TLBP, TLBWI, TLBWR) against the single shared TLB array.
- Pulses the matching CP0 update strobes (tlbr_req, tlbp_req, tlbwr_req) with their result data.
- Blocks MMU translation lookups while it owns the TLB.
- Sits between the WB-stage instruction decode, the CP0 register file and the TLB array.

---
 rtl/tlb_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_tlb_op_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_sequencer.sv
// TLB maintenance sequencer: runs TLBR/TLBP/TLBWI/TLBWR against the shared TLB
// array, raises the CP0 update strobes and blocks translation while it owns the TLB.

package tlb_op_pkg;
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        OP_TLBR  = 2'd0,
        OP_TLBP  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } tlb_op_e;
endpackage

module tlb_op_sequencer
    import tlb_op_pkg::*;
#(
    parameter  int N_TLB_ENTRIES = 32,
    localparam int TLB_WIDTH     = $clog2(N_TLB_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    input  logic [1:0]           op_type,
    output logic                 op_ready,
    output logic                 op_done,
    input  logic                 flush,
    input  logic [TLB_WIDTH-1:0] cp0_index,
    input  logic [TLB_WIDTH-1:0] cp0_random,
    input  tlb_entry_t           cp0_wrdata,
    output logic [TLB_WIDTH-1:0] tlb_raddr,
    input  tlb_entry_t           tlb_rdata,
    output logic [18:0]          tlb_probe_vpn2,
    output logic [7:0]           tlb_probe_asid,
    input  logic                 tlb_probe_hit,
    input  logic [TLB_WIDTH-1:0] tlb_probe_idx,
    output logic                 tlb_we,
    output logic [TLB_WIDTH-1:0] tlb_waddr,
    output tlb_entry_t           tlb_wdata,
    output logic                 lookup_block,
    output logic                 tlbr_req,
    output tlb_entry_t           tlbr_res,
    output logic                 tlbp_req,
    output logic [31:0]          tlbp_res,
    output logic                 tlbwr_req,
    output logic                 itlb_flush
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        PR_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e               state_q, state_d;
    tlb_op_e              op_q;
    logic [TLB_WIDTH-1:0] idx_q;
    tlb_entry_t           entry_q;
    tlb_entry_t           rres_q;
    logic [31:0]          pres_q;
    logic                 accept;
    logic                 idle_live;

    assign accept    = (state_q == IDLE) && op_valid && !flush;
    assign idle_live = (state_q == IDLE) && !rst;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (tlb_op_e'(op_type))
                        OP_TLBR: state_d = RD_WAIT;
                        OP_TLBP: state_d = PR_WAIT;
                        default: state_d = WR;
                    endcase
                end
            end
            RD_WAIT, PR_WAIT: state_d = flush ? IDLE : DONE;
            WR:               state_d = DONE;
            DONE:             state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_TLBR;
            idx_q   <= '0;
            entry_q <= '0;
            rres_q  <= '0;
            pres_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= tlb_op_e'(op_type);
                // Random is captured here so its own advance can't retarget the write
                idx_q   <= (tlb_op_e'(op_type) == OP_TLBWR) ? cp0_random : cp0_index;
                entry_q <= cp0_wrdata;
            end
            if (state_q == RD_WAIT && !flush)
                rres_q <= tlb_rdata;
            if (state_q == PR_WAIT && !flush)
                pres_q <= {~tlb_probe_hit, {(31-TLB_WIDTH){1'b0}},
                           tlb_probe_hit ? tlb_probe_idx : {TLB_WIDTH{1'b0}}};
        end
    end

    // Read address and probe key are presented from the accept cycle so the
    // registered TLB answers in time to be captured at the end of the wait state.
    always_comb begin
        tlb_raddr      = idle_live ? cp0_index : idx_q;
        tlb_probe_vpn2 = idle_live ? cp0_wrdata.vpn2 : entry_q.vpn2;
        tlb_probe_asid = idle_live ? cp0_wrdata.asid : entry_q.asid;
    end

    always_comb begin
        op_ready     = (state_q == IDLE);
        op_done      = (state_q == DONE);
        lookup_block = (state_q == RD_WAIT) || (state_q == PR_WAIT) || (state_q == WR);
        tlb_we       = (state_q == WR);
        tlb_waddr    = idx_q;
        tlb_wdata    = entry_q;
        tlbwr_req    = (state_q == WR) && (op_q == OP_TLBWR);
        tlbr_req     = (state_q == DONE) && (op_q == OP_TLBR);
        tlbp_req     = (state_q == DONE) && (op_q == OP_TLBP);
        itlb_flush   = (state_q == DONE) && ((op_q == OP_TLBWI) || (op_q == OP_TLBWR));
        tlbr_res     = rres_q;
        tlbp_res     = pres_q;
    end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Bench for tlb_op_sequencer: directed vector table, reset corner cases and
// randomized ops checked against a rule-level model with a shadow TLB.

module tb_tlb_op_sequencer;
    import tlb_op_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_ready, op_done, flush;
    logic [1:0]  op_type;
    logic [4:0]  cp0_index, cp0_random, tlb_raddr, tlb_probe_idx, tlb_waddr;
    tlb_entry_t  cp0_wrdata, tlb_rdata, tlb_wdata, tlbr_res;
    logic [18:0] tlb_probe_vpn2;
    logic [7:0]  tlb_probe_asid;
    logic        tlb_probe_hit, tlb_we, lookup_block;
    logic        tlbr_req, tlbp_req, tlbwr_req, itlb_flush;
    logic [31:0] tlbp_res;

    int n_chk = 0;
    int n_fail = 0;

    tlb_op_sequencer #(.N_TLB_ENTRIES(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_type(op_type),
        .op_ready(op_ready), .op_done(op_done), .flush(flush),
        .cp0_index(cp0_index), .cp0_random(cp0_random), .cp0_wrdata(cp0_wrdata),
        .tlb_raddr(tlb_raddr), .tlb_rdata(tlb_rdata),
        .tlb_probe_vpn2(tlb_probe_vpn2), .tlb_probe_asid(tlb_probe_asid),
        .tlb_probe_hit(tlb_probe_hit), .tlb_probe_idx(tlb_probe_idx),
        .tlb_we(tlb_we), .tlb_waddr(tlb_waddr), .tlb_wdata(tlb_wdata),
        .lookup_block(lookup_block), .tlbr_req(tlbr_req), .tlbr_res(tlbr_res),
        .tlbp_req(tlbp_req), .tlbp_res(tlbp_res), .tlbwr_req(tlbwr_req),
        .itlb_flush(itlb_flush)
    );

    always #5 clk = ~clk;

    // TLB array with registered read; preload port used only during reset
    tlb_entry_t mem [32];
    tlb_entry_t ref_mem [32];
    logic       pre_we;
    logic [4:0] pre_addr;
    tlb_entry_t pre_data;

    always @(posedge clk) begin
        tlb_rdata <= mem[tlb_raddr];
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (tlb_we) mem[tlb_waddr] <= tlb_wdata;
    end

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  idx;
        logic [4:0]  rnd;
        logic        fl;
        logic        hit;
        logic [4:0]  pidx;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic        exp_wrreq;
        logic        exp_done;
        logic        exp_rreq;
        logic        exp_preq;
        logic [31:0] exp_pres;
        logic        exp_itlb;
        logic        chg_rnd;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic tlb_entry_t rnd_e();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return tlb_entry_t'(t[77:0]);
    endfunction

    // Expected outcome from the architectural rules of each instruction
    function automatic vec_t model(input logic [1:0] op, input logic [4:0] idx,
                                   input logic [4:0] rnd, input logic fl,
                                   input logic hit, input logic [4:0] pidx,
                                   input logic chg);
        vec_t v;
        bit   is_wr;
        is_wr       = (op == 2'd2) || (op == 2'd3);
        v.op        = op;  v.idx = idx; v.rnd = rnd; v.fl = fl;
        v.hit       = hit; v.pidx = pidx; v.chg_rnd = chg;
        v.exp_we    = is_wr;
        v.exp_waddr = (op == 2'd3) ? rnd : idx;
        v.exp_wrreq = (op == 2'd3);
        v.exp_done  = is_wr || !fl;
        v.exp_rreq  = (op == 2'd0) && !fl;
        v.exp_preq  = (op == 2'd1) && !fl;
        v.exp_pres  = hit ? {27'd0, pidx} : 32'h8000_0000;
        v.exp_itlb  = is_wr;
        return v;
    endfunction

    task automatic run_op(input vec_t v, input tlb_entry_t e);
        tlb_entry_t exp_r;
        @(negedge clk);
        chk("ready_accept", op_ready, 1'b1);
        chk("lblk_accept", lookup_block, 1'b0);
        op_valid = 1'b1; op_type = v.op; flush = 1'b0;
        cp0_index = v.idx; cp0_random = v.rnd; cp0_wrdata = e;
        tlb_probe_hit = v.hit; tlb_probe_idx = v.pidx;
        exp_r = ref_mem[v.idx];
        @(negedge clk);
        // scramble live CP0 inputs to prove the op uses its latched copy
        op_valid = 1'b0; flush = v.fl;
        cp0_index = 5'($urandom); cp0_wrdata = rnd_e();
        if (v.chg_rnd) cp0_random = 5'd0;
        chk("lblk_t1", lookup_block, 1'b1);
        chk("we_t1", tlb_we, v.exp_we);
        chk("wrreq_t1", tlbwr_req, v.exp_wrreq);
        chk("done_t1", op_done, 1'b0);
        chk("strobes_t1", {tlbr_req, tlbp_req, itlb_flush}, 3'b000);
        if (v.exp_we) begin
            chk("waddr_t1", tlb_waddr, v.exp_waddr);
            chk("wdata_t1", tlb_wdata, e);
        end
        if (v.op == 2'd1) chk("probe_key_t1", {tlb_probe_vpn2, tlb_probe_asid}, {e.vpn2, e.asid});
        @(negedge clk);
        flush = 1'b0;
        chk("done_t2", op_done, v.exp_done);
        chk("ready_t2", op_ready, !v.exp_done);
        chk("lblk_t2", lookup_block, 1'b0);
        chk("rreq_t2", tlbr_req, v.exp_rreq);
        chk("preq_t2", tlbp_req, v.exp_preq);
        chk("itlb_t2", itlb_flush, v.exp_itlb);
        chk("we_t2", {tlb_we, tlbwr_req}, 2'b00);
        if (v.exp_rreq) chk("rres_t2", tlbr_res, exp_r);
        if (v.exp_preq) chk("pres_t2", tlbp_res, v.exp_pres);
        if (v.exp_we) ref_mem[v.exp_waddr] = e;
        if (v.exp_done) begin
            @(negedge clk);
            chk("ready_t3", op_ready, 1'b1);
            chk("done_t3", op_done, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    vec_t       vt [9];
    tlb_entry_t e;

    initial begin
        rst = 1'b1; op_valid = 1'b1; op_type = 2'd2; flush = 1'b0;
        cp0_index = 5'd5; cp0_random = 5'd3; cp0_wrdata = rnd_e();
        tlb_probe_hit = 1'b0; tlb_probe_idx = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // reset held with op_valid asserted while the TLB is preloaded
        for (int i = 0; i < 32; i++) begin
            e = rnd_e();
            if (i == 31) e.vpn2 = 19'h1ABCD;
            ref_mem[i] = e;
            @(negedge clk);
            pre_we = 1'b1; pre_addr = 5'(i); pre_data = e;
        end
        @(negedge clk);
        pre_we = 1'b0;
        chk("rst_ready", op_ready, 1'b1);
        chk("rst_outs", {op_done, tlb_we, lookup_block, tlbr_req, tlbp_req, tlbwr_req, itlb_flush}, 7'd0);
        chk("rst_res", {tlbp_res, tlbr_res}, '0);
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0;

        //            op    idx    rnd    fl  hit pidx  we waddr  wrq dn rrq prq pres           itlb chg
        vt[0] = '{2'd2, 5'd5,  5'd9,  0, 0, 5'd0, 1, 5'd5,  0, 1, 0, 0, 32'h0,         1, 0};
        vt[1] = '{2'd0, 5'd31, 5'd2,  0, 0, 5'd0, 0, 5'd0,  0, 1, 1, 0, 32'h0,         0, 0};
        vt[2] = '{2'd1, 5'd0,  5'd0,  0, 1, 5'd7, 0, 5'd0,  0, 1, 0, 1, 32'h0000_0007, 0, 0};
        vt[3] = '{2'd1, 5'd4,  5'd1,  0, 0, 5'd9, 0, 5'd0,  0, 1, 0, 1, 32'h8000_0000, 0, 0};
        vt[4] = '{2'd3, 5'd3,  5'd31, 0, 0, 5'd0, 1, 5'd31, 1, 1, 0, 0, 32'h0,         1, 1};
        vt[5] = '{2'd0, 5'd8,  5'd0,  1, 0, 5'd0, 0, 5'd0,  0, 0, 0, 0, 32'h0,         0, 0};
        vt[6] = '{2'd2, 5'd12, 5'd6,  1, 0, 5'd0, 1, 5'd12, 0, 1, 0, 0, 32'h0,         1, 0};
        vt[7] = '{2'd1, 5'd2,  5'd2,  1, 1, 5'd3, 0, 5'd0,  0, 0, 0, 0, 32'h0,         0, 0};
        vt[8] = '{2'd3, 5'd1,  5'd0,  1, 0, 5'd0, 1, 5'd0,  1, 1, 0, 0, 32'h0,         1, 0};
        for (int i = 0; i < 9; i++) begin
            run_op(vt[i], rnd_e());
            if (i == 1) chk("tlbr_vpn2_31", tlbr_res.vpn2, 19'h1ABCD);
        end

        // reset asserted on the accept cycle of a TLBWI: nothing may be written
        @(negedge clk);
        rst = 1'b1; op_valid = 1'b1; op_type = 2'd2; cp0_index = 5'd5;
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0;
        chk("rstacc_ready", op_ready, 1'b1);
        chk("rstacc_we", {tlb_we, lookup_block}, 2'b00);
        @(negedge clk);
        chk("rstacc_after", {tlb_we, op_done, itlb_flush}, 3'b000);

        // randomized ops, with ignored op_valid+flush cycles sprinkled in
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(3) == 0) begin
                @(negedge clk);
                op_valid = 1'b1; op_type = 2'($urandom); flush = 1'b1;
                @(negedge clk);
                op_valid = 1'b0; flush = 1'b0;
                chk("flush_ignored", {op_ready, lookup_block, tlb_we}, 3'b100);
            end
            run_op(model(2'($urandom), 5'($urandom), 5'($urandom),
                         ($urandom_range(3) == 0), 1'($urandom), 5'($urandom),
                         1'($urandom)), rnd_e());
        end

        // final sweep: the array must match the model's view of every write
        @(negedge clk);
        for (int i = 0; i < 32; i++) chk($sformatf("mem_%0d", i), mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
